// File: rtl/instr_load_mem_if.sv
// ---------------------------------------------------------------------------
// instr_load_mem_if
// Bus bundle between the instruction loader/fetcher and the instruction
// memory.
//
// Signals:
//   LoadInstructions  load mode; one Instruction word is captured per cycle
//   Instruction       word to load
//   fetch_en          fetch request (sampled on the rising clock edge)
//   fetch_addr        word address to fetch
//   fetch_data        registered fetch result
//   fetch_valid       fetch_data carries a new result this cycle
//   load_count        number of words in the current program
//   full              load_count has reached the memory depth
//   load_done         one-cycle pulse after a load burst ends
//   oob               registered with fetch_data; fetch was out of bounds
//
// Handshake: there is no back-pressure. A fetch request is accepted on every
// rising edge where fetch_en=1 while the memory holds a finished program and
// no load is starting. The result appears one cycle later with fetch_valid=1.
// fetch_valid is high for exactly one cycle per accepted request, and
// fetch_data/oob hold their last values while fetch_valid=0.
//
// Modports:
//   master  the side that loads and fetches (drives requests)
//   slave   the memory (drives results and status)
// ---------------------------------------------------------------------------
interface instr_load_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              LoadInstructions;
    logic [DATA_W-1:0] Instruction;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic [ADDR_W:0]   load_count;
    logic              full;
    logic              load_done;
    logic              oob;

    modport master (
        output LoadInstructions, Instruction, fetch_en, fetch_addr,
        input  fetch_data, fetch_valid, load_count, full, load_done, oob
    );

    modport slave (
        input  LoadInstructions, Instruction, fetch_en, fetch_addr,
        output fetch_data, fetch_valid, load_count, full, load_done, oob
    );
endinterface

// File: rtl/instr_load_mem.sv
// ---------------------------------------------------------------------------
// instr_load_mem
// Instruction memory that is filled by a sequential load burst and then read
// by word-addressed fetches with one cycle of latency.
//
// Ports:
//   clk        single clock, rising edge
//   Reset      asynchronous, active-high reset
//   bus        instr_load_mem_if.slave (load inputs, fetch request/result,
//              load status)
//   dbg_state  current FSM state (0 = IDLE, 1 = LOAD, 2 = READY)
//
// Parameters: DATA_W word width, DEPTH number of words (must be 2**ADDR_W),
// ADDR_W word-address width, NOP_WORD word returned for out-of-bounds fetch.
//
// Build option: define IMEM_OOB_NOP_EN to make fetches at or beyond
// load_count return NOP_WORD with oob=1. Without it, fetches return the raw
// memory word and oob stays 0.
//
// The memory array has no reset, so its contents survive Reset and reloads
// except where new words overwrite them.
// ---------------------------------------------------------------------------
module instr_load_mem #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                clk,
    input  logic                Reset,
    instr_load_mem_if.slave     bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [ADDR_W:0]   load_count_q, load_count_next;
    logic              load_done_q, load_done_next;
    logic              full;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              fetch_fire;
    logic              fetch_oob;
    logic [DATA_W-1:0] fetch_data_q;
    logic              fetch_valid_q;
    logic              oob_q;

    logic [DATA_W-1:0] mem [DEPTH];

    assign full = (load_count_q == DEPTH_CNT);

    // Next-state and write control.
    always_comb begin
        state_next      = state;
        load_count_next = load_count_q;
        load_done_next  = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = '0;
        case (state)
            IDLE, READY: begin
                // Starting a new program: the word present this cycle
                // lands at address 0 and the count restarts at 1.
                if (bus.LoadInstructions) begin
                    state_next      = LOAD;
                    wr_en           = 1'b1;
                    wr_addr         = '0;
                    load_count_next = ONE_CNT;
                end
            end
            LOAD: begin
                if (bus.LoadInstructions) begin
                    // Once full, extra words are dropped; the pointer never
                    // wraps back to address 0.
                    if (!full) begin
                        wr_en           = 1'b1;
                        wr_addr         = load_count_q[ADDR_W-1:0];
                        load_count_next = load_count_q + ONE_CNT;
                    end
                end else begin
                    state_next     = READY;
                    load_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A load request in READY takes priority over a fetch in the same cycle.
    assign fetch_fire = (state == READY) && bus.fetch_en && !bus.LoadInstructions;

`ifdef IMEM_OOB_NOP_EN
    assign fetch_oob = ({1'b0, bus.fetch_addr} >= load_count_q);
`else
    assign fetch_oob = 1'b0;
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            load_count_q  <= '0;
            load_done_q   <= 1'b0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            oob_q         <= 1'b0;
        end else begin
            state        <= state_next;
            load_count_q <= load_count_next;
            load_done_q  <= load_done_next;
            if (fetch_fire) begin
                fetch_valid_q <= 1'b1;
                oob_q         <= fetch_oob;
                fetch_data_q  <= fetch_oob ? NOP_WORD : mem[bus.fetch_addr];
            end else begin
                fetch_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.Instruction;
        end
    end

    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.load_count  = load_count_q;
    assign bus.full        = full;
    assign bus.load_done   = load_done_q;
    assign bus.oob         = oob_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_instr_load_mem.sv
// ---------------------------------------------------------------------------
// tb_instr_load_mem
// Self-checking bench for instr_load_mem: directed scenarios plus a random
// run, compared against a program-level reference model (array of words,
// word count, loading/ready flags).
// ---------------------------------------------------------------------------
module tb_instr_load_mem;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam logic [DATA_W-1:0] NOP = '0;

    logic       clk = 1'b0;
    logic       Reset;
    logic [1:0] dbg_state;

    instr_load_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_load_mem #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .Reset(Reset), .bus(bus), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_known [DEPTH];
    int                m_count;
    bit                m_loading;
    bit                m_ready;
    logic [DATA_W-1:0] e_data;
    bit                e_data_known;
    bit                e_valid, e_oob, e_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Applies the current inputs for one clock edge and advances the model
    // by the program-level rules; returns at posedge + 1.
    task automatic tick();
        bit li = bus.LoadInstructions;
        bit fe = bus.fetch_en;
        int a  = int'(bus.fetch_addr);
        e_done = 1'b0;
        if (li) begin
            if (!m_loading) begin
                m_loading = 1'b1;
                m_ready   = 1'b0;
                m_count   = 0;
            end
            if (m_count < DEPTH) begin
                m_mem[m_count]   = bus.Instruction;
                m_known[m_count] = 1'b1;
                m_count++;
            end
            e_valid = 1'b0;
        end else begin
            if (m_ready && fe) begin
                e_valid = 1'b1;
`ifdef IMEM_OOB_NOP_EN
                e_oob = (a >= m_count);
`else
                e_oob = 1'b0;
`endif
                e_data       = e_oob ? NOP : m_mem[a];
                e_data_known = e_oob || m_known[a];
            end else begin
                e_valid = 1'b0;
            end
            if (m_loading) begin
                m_loading = 1'b0;
                m_ready   = 1'b1;
                e_done    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset                = 1'b1;
        bus.LoadInstructions = 1'b0;
        bus.fetch_en         = 1'b0;
        m_loading = 1'b0; m_ready = 1'b0; m_count = 0;
        e_data = '0; e_data_known = 1'b1;
        e_valid = 1'b0; e_oob = 1'b0; e_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.Instruction = '0;
        bus.fetch_addr  = '0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        apply_reset();
        n_checks++;
        if ({bus.fetch_valid, bus.oob, bus.load_done, bus.full} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.fetch_valid, bus.oob, bus.load_done, bus.full});
        end
        n_checks++;
        if (bus.load_count !== 7'd0 || bus.fetch_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_count_data: got count %0d data %h expected 0 / 0",
                     bus.load_count, bus.fetch_data);
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
    endtask

    // 67 words with value = index into a 64-word memory.
    task automatic test_overflow();
        bus.LoadInstructions = 1'b1;
        for (int i = 0; i < 67; i++) begin
            bus.Instruction = DATA_W'(i);
            tick();
            n_checks++;
            if (bus.full !== (i >= 63) || bus.load_count !== 7'((i >= 63) ? 64 : i + 1)) begin
                n_fail++;
                $display("FAIL overflow_count[%0d]: got full %b count %0d expected full %b count %0d",
                         i, bus.full, bus.load_count, (i >= 63), (i >= 63) ? 64 : i + 1);
            end
        end
        bus.LoadInstructions = 1'b0;
        tick();
        n_checks++;
        if (bus.load_done !== 1'b1 || bus.load_count !== 7'd64) begin
            n_fail++;
            $display("FAIL overflow_done: got done %b count %0d expected 1 / 64",
                     bus.load_done, bus.load_count);
        end
        bus.fetch_en = 1'b1; bus.fetch_addr = 6'd0;
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'd0 || bus.load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_fetch0: got valid %b data %h done %b expected 1 / 0 / 0",
                     bus.fetch_valid, bus.fetch_data, bus.load_done);
        end
        bus.fetch_addr = 6'd63;
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'd63) begin
            n_fail++;
            $display("FAIL overflow_fetch63: got valid %b data %h expected 1 / 3f",
                     bus.fetch_valid, bus.fetch_data);
        end
        bus.fetch_en = 1'b0;
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b0 || bus.fetch_data !== 32'd63) begin
            n_fail++;
            $display("FAIL fetch_hold: got valid %b data %h expected 0 / 3f",
                     bus.fetch_valid, bus.fetch_data);
        end
    endtask

    task automatic test_load_basic();
        logic [DATA_W-1:0] words [5];
        words[0] = 32'h200101A7; words[1] = 32'h2002005C; words[2] = 32'h2003000D;
        words[3] = 32'h20040092; words[4] = 32'h20050005;
        apply_reset();
        bus.LoadInstructions = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.Instruction = words[i];
            tick();
        end
        bus.LoadInstructions = 1'b0;
        tick();
        n_checks++;
        if (bus.load_done !== 1'b1 || bus.load_count !== 7'd5 || dbg_state !== 2'd2) begin
            n_fail++;
            $display("FAIL basic_done: got done %b count %0d state %0d expected 1 / 5 / 2",
                     bus.load_done, bus.load_count, dbg_state);
        end
        bus.fetch_en = 1'b1; bus.fetch_addr = 6'd2;
        tick();
        n_checks++;
        if (bus.load_done !== 1'b0 || bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h2003000D) begin
            n_fail++;
            $display("FAIL basic_fetch2: got done %b valid %b data %h expected 0 / 1 / 2003000d",
                     bus.load_done, bus.fetch_valid, bus.fetch_data);
        end
        bus.fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_oob();
        logic [DATA_W-1:0] exp_d;
        logic              exp_o;
`ifdef IMEM_OOB_NOP_EN
        exp_d = NOP;   exp_o = 1'b1;
`else
        exp_d = 32'd7; exp_o = 1'b0;
`endif
        bus.fetch_en = 1'b1; bus.fetch_addr = 6'd7;
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== exp_d || bus.oob !== exp_o) begin
            n_fail++;
            $display("FAIL oob_fetch7: got valid %b data %h oob %b expected 1 / %h / %b",
                     bus.fetch_valid, bus.fetch_data, bus.oob, exp_d, exp_o);
        end
        bus.fetch_addr = 6'd4;
        tick();
        n_checks++;
        if (bus.fetch_data !== 32'h20050005 || bus.oob !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_fetch4: got data %h oob %b expected 20050005 / 0",
                     bus.fetch_data, bus.oob);
        end
        bus.fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_reload();
        logic [DATA_W-1:0] exp_d;
        logic              exp_o;
`ifdef IMEM_OOB_NOP_EN
        exp_d = NOP;          exp_o = 1'b1;
`else
        exp_d = 32'h20040092; exp_o = 1'b0;
`endif
        bus.LoadInstructions = 1'b1;
        bus.Instruction = 32'hAAAA0001; tick();
        bus.Instruction = 32'hAAAA0002; tick();
        bus.LoadInstructions = 1'b0;
        tick();
        n_checks++;
        if (bus.load_count !== 7'd2 || bus.load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_count: got count %0d done %b expected 2 / 1",
                     bus.load_count, bus.load_done);
        end
        bus.fetch_en = 1'b1; bus.fetch_addr = 6'd1;
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'hAAAA0002) begin
            n_fail++;
            $display("FAIL reload_fetch1: got valid %b data %h expected 1 / aaaa0002",
                     bus.fetch_valid, bus.fetch_data);
        end
        bus.fetch_addr = 6'd3;
        tick();
        n_checks++;
        if (bus.fetch_data !== exp_d || bus.oob !== exp_o) begin
            n_fail++;
            $display("FAIL reload_fetch3: got data %h oob %b expected %h / %b",
                     bus.fetch_data, bus.oob, exp_d, exp_o);
        end
        // Load and fetch in the same READY cycle: load wins.
        bus.fetch_addr = 6'd0; bus.LoadInstructions = 1'b1; bus.Instruction = 32'hBBBB0000;
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b0 || dbg_state !== 2'd1 || bus.load_count !== 7'd1) begin
            n_fail++;
            $display("FAIL load_wins: got valid %b state %0d count %0d expected 0 / 1 / 1",
                     bus.fetch_valid, dbg_state, bus.load_count);
        end
        bus.LoadInstructions = 1'b0; bus.fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        bus.LoadInstructions = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.Instruction = 32'hC0DE0000 + DATA_W'(i);
            tick();
        end
        // Assert between edges; outputs must clear without a clock edge.
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.fetch_valid, bus.oob, bus.load_done, bus.full} !== 4'b0000 ||
            bus.load_count !== 7'd0 || bus.fetch_data !== 32'd0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got flags %b count %0d data %h state %0d expected 0 / 0 / 0 / 0",
                     {bus.fetch_valid, bus.oob, bus.load_done, bus.full},
                     bus.load_count, bus.fetch_data, dbg_state);
        end
        @(posedge clk); #1;
        apply_reset();
        bus.fetch_en = 1'b1; bus.fetch_addr = 6'd0;
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_fetch: got valid %b expected 0", bus.fetch_valid);
        end
        bus.fetch_en = 1'b0;
        bus.LoadInstructions = 1'b1; bus.Instruction = 32'h00000055;
        tick();
        bus.LoadInstructions = 1'b0;
        tick();
        bus.fetch_en = 1'b1; bus.fetch_addr = 6'd0;
        tick();
        n_checks++;
        if (bus.fetch_data !== 32'h00000055 || bus.load_count !== 7'd1) begin
            n_fail++;
            $display("FAIL restart_addr0: got data %h count %0d expected 00000055 / 1",
                     bus.fetch_data, bus.load_count);
        end
        bus.fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_fetch_during_load();
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 6'd1;
        bus.LoadInstructions = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.Instruction = DATA_W'($urandom);
            tick();
            n_checks++;
            if (bus.fetch_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_fetch_ignored[%0d]: got valid %b expected 0", i, bus.fetch_valid);
            end
        end
        bus.LoadInstructions = 1'b0;
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b0 || bus.load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL first_ready: got valid %b done %b expected 0 / 1",
                     bus.fetch_valid, bus.load_done);
        end
        tick();
        n_checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== e_data) begin
            n_fail++;
            $display("FAIL first_fetch: got valid %b data %h expected 1 / %h",
                     bus.fetch_valid, bus.fetch_data, e_data);
        end
        bus.fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end
            bus.LoadInstructions = ($urandom_range(0, 3) == 0) ||
                                   (bus.LoadInstructions && $urandom_range(0, 7) != 0);
            bus.Instruction = DATA_W'($urandom);
            bus.fetch_en    = ($urandom_range(0, 1) == 1);
            bus.fetch_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
            n_checks++;
            if (bus.fetch_valid !== e_valid || bus.oob !== e_oob || bus.load_done !== e_done ||
                bus.load_count !== (ADDR_W + 1)'(m_count) || bus.full !== (m_count == DEPTH) ||
                (e_data_known && bus.fetch_data !== e_data)) begin
                n_fail++;
                $display("FAIL random[%0d]: got v%b o%b d%b c%0d f%b data %h expected v%b o%b d%b c%0d f%b data %h",
                         i, bus.fetch_valid, bus.oob, bus.load_done, bus.load_count, bus.full,
                         bus.fetch_data, e_valid, e_oob, e_done, m_count, (m_count == DEPTH), e_data);
            end
        end
    endtask

    initial begin
        Reset                = 1'b1;
        bus.LoadInstructions = 1'b0;
        bus.fetch_en         = 1'b0;
        test_reset();
        test_overflow();
        test_load_basic();
        test_oob();
        test_reload();
        test_reset_mid_load();
        test_fetch_during_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
